// File: rtl/cache_pkg.sv
// Shared widths, FSM state encoding and word-select helper for the direct-mapped read cache.
package cache_pkg;
    localparam int ADDR_W  = 15;
    localparam int INDEX_W = 10;
    localparam int OFFS_W  = 2;
    localparam int TAG_W   = ADDR_W - INDEX_W - OFFS_W;
    localparam int WORD_W  = 32;
    localparam int BLOCK_W = WORD_W << OFFS_W;
    localparam int LINES   = 2 ** INDEX_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MREQ  = 3'd1,
        MWAIT = 3'd2,
        FILL  = 3'd3,
        REL   = 3'd4
    } state_t;

    function automatic logic [WORD_W-1:0] get_word(input logic [BLOCK_W-1:0] blk,
                                                   input logic [OFFS_W-1:0]  offs);
        return blk[{offs, 5'b00000} +: WORD_W];
    endfunction
endpackage

// File: rtl/cache_controller_if.sv
// CPU load port and main-memory read port bundle; the cache sits on the slave modport.
interface cache_controller_if;
    logic                                cpu_read;
    logic [cache_pkg::ADDR_W-1:0]        cpu_address;
    logic                                cpu_ready;
    logic [cache_pkg::WORD_W-1:0]        cpu_data;
    logic [cache_pkg::ADDR_W-1:0]        mem_address;
    logic                                mem_read;
    logic                                mem_data_ready;
    logic [cache_pkg::BLOCK_W-1:0]       mem_data_block;

    modport slave (
        input  cpu_read, cpu_address, mem_data_ready, mem_data_block,
        output cpu_ready, cpu_data, mem_address, mem_read
    );

    modport master (
        output cpu_read, cpu_address, mem_data_ready, mem_data_block,
        input  cpu_ready, cpu_data, mem_address, mem_read
    );
endinterface

// File: rtl/cache_data_array.sv
// Block data and tag stores: combinational read, synchronous write on one enable; not reset.
module cache_data_array
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic [INDEX_W-1:0] i_rd_idx,
    output logic [TAG_W-1:0]   o_rd_tag,
    output logic [BLOCK_W-1:0] o_rd_data,
    input  logic               i_we,
    input  logic [INDEX_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0]   i_wr_tag,
    input  logic [BLOCK_W-1:0] i_wr_data
);
    logic [BLOCK_W-1:0] r_data [LINES];
    logic [TAG_W-1:0]   r_tag  [LINES];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_data[i_wr_idx] <= i_wr_data;
            r_tag[i_wr_idx]  <= i_wr_tag;
        end
    end

    assign o_rd_tag  = r_tag[i_rd_idx];
    assign o_rd_data = r_data[i_rd_idx];
endmodule

// File: rtl/cache_controller.sv
// Direct-mapped read cache with miss sequencer. Optional hit/miss counters when CACHE_STATS_EN
// is defined.
module cache_controller
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    cache_controller_if.slave  bus
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]        hit_count,
    output logic [31:0]        miss_count
`endif
);
    state_t             r_state;
    state_t             w_next_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [LINES-1:0]   r_valid;
    logic               r_cpu_ready;
    logic [WORD_W-1:0]  r_cpu_data;

    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [OFFS_W-1:0]  w_offs;
    logic [INDEX_W-1:0] w_r_idx;
    logic [TAG_W-1:0]   w_rd_tag;
    logic [BLOCK_W-1:0] w_rd_data;
    logic               w_hit;
    logic               w_req;
    logic               w_fill;
    logic               w_mem_read;

    assign w_tag   = bus.cpu_address[ADDR_W-1 -: TAG_W];
    assign w_idx   = bus.cpu_address[OFFS_W +: INDEX_W];
    assign w_offs  = bus.cpu_address[OFFS_W-1:0];
    assign w_r_idx = r_addr[OFFS_W +: INDEX_W];

    assign w_hit  = r_valid[w_idx] && (w_rd_tag == w_tag);
    assign w_req  = (r_state == IDLE) && bus.cpu_read;
    assign w_fill = (r_state == MWAIT) && bus.mem_data_ready;

    cache_data_array u_array (
        .clk       (clk),
        .i_rd_idx  (w_idx),
        .o_rd_tag  (w_rd_tag),
        .o_rd_data (w_rd_data),
        .i_we      (w_fill),
        .i_wr_idx  (w_r_idx),
        .i_wr_tag  (r_addr[ADDR_W-1 -: TAG_W]),
        .i_wr_data (bus.mem_data_block)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_req && !w_hit) w_next_state = MREQ;
            MREQ:    w_next_state = MWAIT;
            MWAIT:   if (bus.mem_data_ready) w_next_state = FILL;
            FILL:    w_next_state = REL;
            REL:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Strobe is decoded from state so an async reset drops it at once.
    always_comb begin
        w_mem_read = 1'b0;
        case (r_state)
            MREQ, MWAIT: w_mem_read = 1'b1;
            default:     w_mem_read = 1'b0;
        endcase
    end

    // Fill data is captured on the edge that sees mem_data_ready, so the block only has to be
    // valid while the strobe is still high; FILL is the cycle where the answer is visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr      <= '0;
            r_valid     <= '0;
            r_cpu_ready <= 1'b0;
            r_cpu_data  <= '0;
        end else begin
            r_cpu_ready <= 1'b0;
            if (w_req) begin
                r_addr <= bus.cpu_address;
                if (w_hit) begin
                    r_cpu_ready <= 1'b1;
                    r_cpu_data  <= get_word(w_rd_data, w_offs);
                end
            end
            if (w_fill) begin
                r_valid[w_r_idx] <= 1'b1;
                r_cpu_ready      <= 1'b1;
                r_cpu_data       <= get_word(bus.mem_data_block, r_addr[OFFS_W-1:0]);
            end
        end
    end

    assign bus.mem_read    = w_mem_read;
    assign bus.mem_address = {r_addr[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
    assign bus.cpu_ready   = r_cpu_ready;
    assign bus.cpu_data    = r_cpu_data;

`ifdef CACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (w_req) begin
            if (w_hit) r_hit_count  <= r_hit_count + 32'd1;
            else       r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif
endmodule
